// File: rtl/sr_chk_pkg.sv
// Shared definitions for the SR flip-flop response checker: FSM state encoding
// and the saturating counter increment used by every counter in the checker.
package sr_chk_pkg;

  typedef enum logic [1:0] {
    ST_UNKNOWN = 2'd0,
    ST_TRACK   = 2'd1,
    ST_HALTED  = 2'd2
  } state_t;

  localparam int unsigned MAX_CNT_W = 32;

  // Counters stick at all-ones of their own width instead of wrapping to zero.
  function automatic logic [MAX_CNT_W-1:0] satInc(input logic [MAX_CNT_W-1:0] value,
                                                  input int unsigned          width);
    logic [MAX_CNT_W-1:0] maxVal;
    maxVal = (width >= MAX_CNT_W) ? '1 : ((MAX_CNT_W'(1) << width) - MAX_CNT_W'(1));
    return (value == maxVal) ? value : value + MAX_CNT_W'(1);
  endfunction

endpackage

// File: rtl/sr_chk_delay.sv
// Delay line for the reference model: carries {ref, vld} forward by LATENCY
// enabled edges so it lines up with the DUT output it predicts.
module sr_chk_delay #(
  parameter int LATENCY = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic ref_i,
  input  logic vld_i,
  output logic ref_o,
  output logic vld_o
);

  logic [LATENCY-1:0] refPipe_q;
  logic [LATENCY-1:0] vldPipe_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      refPipe_q <= '0;
      vldPipe_q <= '0;
    end else if (en_i) begin
      refPipe_q[0] <= ref_i;
      vldPipe_q[0] <= vld_i;
      for (int i = LATENCY - 1; i > 0; i--) begin
        refPipe_q[i] <= refPipe_q[i-1];
        vldPipe_q[i] <= vldPipe_q[i-1];
      end
    end
  end

  assign ref_o = refPipe_q[LATENCY-1];
  assign vld_o = vldPipe_q[LATENCY-1];

endmodule

// File: rtl/sr_ff_checker.sv
// Response checker for an SR flip-flop: tracks a reference q from the sampled
// s/r stream, compares the delayed prediction against q/q_bar, and keeps stats.
module sr_ff_checker
  import sr_chk_pkg::*;
#(
  parameter int LATENCY     = 1,
  parameter int CNT_W       = 16,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             s,
  input  logic             r,
  input  logic             q,
  input  logic             q_bar,
  output logic [1:0]       state,
  output logic             err,
  output logic             err_pulse,
  output logic [CNT_W-1:0] check_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] illegal_cnt,
  output logic [CNT_W-1:0] first_err_cycle,
  output logic             first_err_exp,
  output logic [1:0]       first_err_act
);

  state_t           state_q, state_d;
  logic             refBit_q, refBit_d;
  logic             refVld_q, refVld_d;
  logic             dlyRef, dlyVld;
  logic             active, illegal, compare, mismatch;
  logic             err_q, errPulse_q;
  logic [CNT_W-1:0] checkCnt_q, mismatchCnt_q, illegalCnt_q, firstErrCycle_q;
  logic             firstErrExp_q;
  logic [1:0]       firstErrAct_q;

  // HALTED freezes the model, the pipe and every counter until reset.
  always_comb begin
    active   = en && (state_q != ST_HALTED);
    illegal  = active && s && r;
    compare  = active && dlyVld;
    mismatch = compare && ((q != dlyRef) || (q_bar == q));

    refBit_d = refBit_q;
    refVld_d = refVld_q;
    if (s && !r) begin
      refBit_d = 1'b1;
      refVld_d = 1'b1;
    end else if (!s && r) begin
      refBit_d = 1'b0;
      refVld_d = 1'b1;
    end else if (s && r) begin
      refVld_d = 1'b0;
    end

    state_d = state_q;
    if (active) begin
      case (state_q)
        ST_UNKNOWN: if (s ^ r) state_d = ST_TRACK;
        ST_TRACK: begin
          if (STOP_ON_ERR && mismatch) state_d = ST_HALTED;
          else if (s && r)             state_d = ST_UNKNOWN;
        end
        default:    state_d = state_q;
      endcase
    end
  end

  sr_chk_delay #(
    .LATENCY(LATENCY)
  ) u_delay (
    .clk_i(clk),
    .rst_i(rst),
    .en_i (active),
    .ref_i(refBit_d),
    .vld_i(refVld_d),
    .ref_o(dlyRef),
    .vld_o(dlyVld)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_UNKNOWN;
      refBit_q        <= 1'b0;
      refVld_q        <= 1'b0;
      err_q           <= 1'b0;
      errPulse_q      <= 1'b0;
      checkCnt_q      <= '0;
      mismatchCnt_q   <= '0;
      illegalCnt_q    <= '0;
      firstErrCycle_q <= '0;
      firstErrExp_q   <= 1'b0;
      firstErrAct_q   <= 2'b00;
    end else begin
      state_q    <= state_d;
      errPulse_q <= mismatch;
      if (active) begin
        refBit_q <= refBit_d;
        refVld_q <= refVld_d;
      end
      if (compare) checkCnt_q <= CNT_W'(satInc(MAX_CNT_W'(checkCnt_q), CNT_W));
      if (illegal) illegalCnt_q <= CNT_W'(satInc(MAX_CNT_W'(illegalCnt_q), CNT_W));
      if (mismatch) begin
        mismatchCnt_q <= CNT_W'(satInc(MAX_CNT_W'(mismatchCnt_q), CNT_W));
        err_q         <= 1'b1;
        // The sticky err bit doubles as the "first error already captured" flag.
        if (!err_q) begin
          firstErrCycle_q <= checkCnt_q;
          firstErrExp_q   <= dlyRef;
          firstErrAct_q   <= {q, q_bar};
        end
      end
    end
  end

  assign state           = state_q;
  assign err             = err_q;
  assign err_pulse       = errPulse_q;
  assign check_cnt       = checkCnt_q;
  assign mismatch_cnt    = mismatchCnt_q;
  assign illegal_cnt     = illegalCnt_q;
  assign first_err_cycle = firstErrCycle_q;
  assign first_err_exp   = firstErrExp_q;
  assign first_err_act   = firstErrAct_q;

endmodule
